score_counter_mc: RTL and testbench

- Multi-channel up/down score counter for the scoreboard, one channel per team. It is the single-clock successor to the dual-clock up/down counter.
- Raw button levels are synchronised and rising-edge detected in the clk_i domain. Each press steps the channel's count by one within [0, MAX_VAL].
- The count either saturates or wraps at the limits, selected by parameter.
- Per-channel counts and limit flags feed the display/decoder stage.

---
 rtl/score_counter_mc.sv | 94 +++++++++
 tb/tb_score_counter_mc.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/score_counter_mc.sv
// Multi-channel up/down score counter.
// Raw button levels are synchronised and rising-edge detected in the clk_i domain.
// Each detected press steps that channel's count by one within [0, MAX_VAL].
// At the limits the count either saturates (WRAP=0) or wraps around (WRAP=1).
module score_counter_mc #(
  parameter int BW      = 7,
  parameter int MAX_VAL = 99,
  parameter int NCH     = 2,
  parameter int WRAP    = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NCH-1:0]    up_i,
  input  logic [NCH-1:0]    down_i,
  input  logic              clr_i,
  output logic [NCH*BW-1:0] cnt_o,
  output logic [NCH-1:0]    at_max_o,
  output logic [NCH-1:0]    at_zero_o
);

  localparam logic [BW-1:0] MAX_C = BW'(MAX_VAL);

  // Two synchroniser stages (s1, s2) plus a delay stage (s3) for edge detection.
  logic [NCH-1:0] up_s1_reg, up_s2_reg, up_s3_reg;
  logic [NCH-1:0] dn_s1_reg, dn_s2_reg, dn_s3_reg;
  logic [NCH-1:0] ev_up, ev_dn;

  // Synchronise the button levels and keep one extra delayed copy.
  // This chain keeps running while clr_i is high, so a cleared event is never replayed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      up_s1_reg <= '0;
      up_s2_reg <= '0;
      up_s3_reg <= '0;
      dn_s1_reg <= '0;
      dn_s2_reg <= '0;
      dn_s3_reg <= '0;
    end else begin
      up_s1_reg <= up_i;
      up_s2_reg <= up_s1_reg;
      up_s3_reg <= up_s2_reg;
      dn_s1_reg <= down_i;
      dn_s2_reg <= dn_s1_reg;
      dn_s3_reg <= dn_s2_reg;
    end
  end

  // A one-cycle event marks each low->high transition of a synchronised level.
  assign ev_up = up_s2_reg & ~up_s3_reg;
  assign ev_dn = dn_s2_reg & ~dn_s3_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [BW-1:0] cnt_reg, cnt_next;

      // Next count: clear first, then cancel opposing events, then step within the limits.
      always_comb begin
        cnt_next = cnt_reg;
        if (clr_i) begin
          cnt_next = '0;
        end else if (ev_up[gi] && !ev_dn[gi]) begin
          // Compare before incrementing, so the sum never overflows BW bits.
          if (cnt_reg < MAX_C) begin
            cnt_next = cnt_reg + BW'(1);
          end else if (WRAP != 0) begin
            cnt_next = '0;
          end
        end else if (ev_dn[gi] && !ev_up[gi]) begin
          if (cnt_reg != '0) begin
            cnt_next = cnt_reg - BW'(1);
          end else if (WRAP != 0) begin
            cnt_next = MAX_C;
          end
        end
      end

      // Count register; asynchronous reset drops the count to zero immediately.
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      // The limit flags decode the registered count, so they move together with cnt_o.
      assign cnt_o[gi*BW +: BW] = cnt_reg;
      assign at_max_o[gi]       = (cnt_reg == MAX_C);
      assign at_zero_o[gi]      = (cnt_reg == '0);
    end
  endgenerate

endmodule

// File: tb/tb_score_counter_mc.sv
// Self-checking bench for score_counter_mc.
// Instance u_sat uses the defaults (saturating, 0..99, two channels).
// Instance u_wrap uses the wrapping mode (0..9, BW=4, one channel).
module tb_score_counter_mc;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [1:0]  up = '0;
  logic [1:0]  down = '0;
  logic        clr = 1'b0;
  logic [13:0] cnt;
  logic [1:0]  at_max, at_zero;

  logic [0:0]  up_w = '0;
  logic [0:0]  down_w = '0;
  logic [3:0]  cnt_w;
  logic [0:0]  at_max_w, at_zero_w;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk_i = ~clk_i;

  score_counter_mc u_sat (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .up_i      (up),
    .down_i    (down),
    .clr_i     (clr),
    .cnt_o     (cnt),
    .at_max_o  (at_max),
    .at_zero_o (at_zero)
  );

  score_counter_mc #(.BW(4), .MAX_VAL(9), .NCH(1), .WRAP(1)) u_wrap (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .up_i      (up_w),
    .down_i    (down_w),
    .clr_i     (clr),
    .cnt_o     (cnt_w),
    .at_max_o  (at_max_w),
    .at_zero_o (at_zero_w)
  );

  typedef struct {
    logic [1:0] up;
    logic [1:0] down;
    logic       clr;
    int         e0;
    int         e1;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Check both channels of the saturating instance plus their flags.
  task automatic check_sat(input string name, input int e0, input int e1);
    int ez, em;
    ez = ((e1 == 0) ? 2 : 0) + ((e0 == 0) ? 1 : 0);
    em = ((e1 == 99) ? 2 : 0) + ((e0 == 99) ? 1 : 0);
    check({name, " ch0"}, int'(cnt[6:0]), e0);
    check({name, " ch1"}, int'(cnt[13:7]), e1);
    check({name, " at_zero"}, int'(at_zero), ez);
    check({name, " at_max"}, int'(at_max), em);
  endtask

  // Drive button levels for 'high' cycles, release, and let the chain settle.
  task automatic press(input logic [1:0] um, input logic [1:0] dm,
                       input logic uw, input logic dw, input int high);
    @(negedge clk_i);
    up = um; down = dm; up_w = uw; down_w = dw;
    repeat (high) @(negedge clk_i);
    up = '0; down = '0; up_w = '0; down_w = '0;
    repeat (3) @(negedge clk_i);
  endtask

  initial begin
    vecs[0] = '{2'b01, 2'b00, 1'b0, 6, 0};
    vecs[1] = '{2'b10, 2'b00, 1'b0, 6, 1};
    vecs[2] = '{2'b11, 2'b00, 1'b0, 7, 2};
    vecs[3] = '{2'b00, 2'b01, 1'b0, 6, 2};
    vecs[4] = '{2'b00, 2'b10, 1'b0, 6, 1};
    vecs[5] = '{2'b01, 2'b01, 1'b0, 6, 1};
    vecs[6] = '{2'b01, 2'b10, 1'b0, 7, 0};
    vecs[7] = '{2'b00, 2'b00, 1'b1, 0, 0};
    vecs[8] = '{2'b00, 2'b11, 1'b0, 0, 0};
    vecs[9] = '{2'b10, 2'b00, 1'b0, 0, 1};

    // Reset state.
    repeat (3) @(negedge clk_i);
    check_sat("reset", 0, 0);
    check("reset wrap cnt", int'(cnt_w), 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Five presses with exact latency: level set before edge k, count moves at edge k+2.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      up = 2'b01;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      check("latency k+1 ch0", int'(cnt[6:0]), i);
      @(posedge clk_i); #1;
      check("latency k+2 ch0", int'(cnt[6:0]), i + 1);
      @(negedge clk_i);
      up = 2'b00;
      repeat (3) @(negedge clk_i);
    end
    check_sat("five ups", 5, 0);

    // Table-driven vectors.
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].clr) begin
        @(negedge clk_i); clr = 1'b1;
        @(negedge clk_i); clr = 1'b0;
        @(negedge clk_i);
      end else begin
        press(vecs[v].up, vecs[v].down, 1'b0, 1'b0, 3);
      end
      check_sat($sformatf("vec%0d", v), vecs[v].e0, vecs[v].e1);
    end

    // Held button counts once; release and re-press counts again.
    @(negedge clk_i); up = 2'b10;
    repeat (50) @(negedge clk_i);
    check("held ch1", int'(cnt[13:7]), 2);
    up = 2'b00;
    repeat (3) @(negedge clk_i);
    check("held released ch1", int'(cnt[13:7]), 2);
    press(2'b10, 2'b00, 1'b0, 1'b0, 2);
    check("re-press ch1", int'(cnt[13:7]), 3);

    // Saturation at both limits with minimum-width presses.
    @(negedge clk_i); clr = 1'b1;
    @(negedge clk_i); clr = 1'b0;
    for (int i = 0; i < 105; i++) press(2'b01, 2'b00, 1'b0, 1'b0, 2);
    check_sat("sat 105 ups", 99, 0);
    press(2'b01, 2'b00, 1'b0, 1'b0, 2);
    check_sat("sat extra up", 99, 0);
    for (int i = 0; i < 100; i++) press(2'b00, 2'b01, 1'b0, 1'b0, 2);
    check_sat("sat 100 downs", 0, 0);
    press(2'b00, 2'b01, 1'b0, 1'b0, 2);
    check_sat("sat extra down", 0, 0);

    // Wrap instance: climb to 9, wrap up to 0, wrap down to 9.
    for (int i = 0; i < 9; i++) press(2'b00, 2'b00, 1'b1, 1'b0, 2);
    check("wrap reach 9", int'(cnt_w), 9);
    check("wrap at_max", int'(at_max_w), 1);
    press(2'b00, 2'b00, 1'b1, 1'b0, 2);
    check("wrap up 9->0", int'(cnt_w), 0);
    check("wrap at_zero", int'(at_zero_w), 1);
    press(2'b00, 2'b00, 1'b0, 1'b1, 2);
    check("wrap down 0->9", int'(cnt_w), 9);

    // Simultaneous events: ch0 up+down cancel, ch1 up still counts.
    for (int i = 0; i < 10; i++) press(2'b01, 2'b00, 1'b0, 1'b0, 2);
    check_sat("ch0 at 10", 10, 0);
    press(2'b11, 2'b01, 1'b0, 1'b0, 3);
    check_sat("simultaneous", 10, 1);

    // Build ch0=42, ch1=7, then clear while an up event on ch0 is in flight.
    for (int i = 0; i < 6; i++) press(2'b11, 2'b00, 1'b0, 1'b0, 2);
    for (int i = 0; i < 26; i++) press(2'b01, 2'b00, 1'b0, 1'b0, 2);
    check_sat("preclear", 42, 7);
    @(negedge clk_i); up = 2'b01;
    @(negedge clk_i);
    @(negedge clk_i); clr = 1'b1;
    @(negedge clk_i); clr = 1'b0; up = 2'b00;
    check_sat("clear in flight", 0, 0);
    repeat (5) @(negedge clk_i);
    check_sat("no replay", 0, 0);

    // Raise counts, then drop reset mid-cycle: counts clear without a clock edge.
    for (int i = 0; i < 3; i++) press(2'b11, 2'b00, 1'b0, 1'b0, 2);
    check_sat("before async reset", 3, 3);
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    #1;
    check_sat("async reset", 0, 0);

    // Button held across reset release yields exactly one event.
    @(negedge clk_i); up = 2'b01;
    @(negedge clk_i); rst_i = 1'b1;
    repeat (6) @(negedge clk_i);
    check_sat("held through reset", 1, 0);
    up = 2'b00;
    repeat (3) @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
